// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache.
// Ports: clk_i/rst_i (sync, active-high); cpu_* MEM-stage side with
// cpu_stall_o freezing the pipeline on a miss; mem_* word-wide req/ack
// memory side; hit_count_o/miss_count_o statistics, live only when
// DCACHE_STATS_EN is defined (tied to 0 otherwise).
module dcache_ctrl #(
  parameter int NUM_SETS = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
);

  localparam int IDX  = $clog2(NUM_SETS);
  localparam int TAGW = 30 - IDX;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAGW-1:0]     tag_q  [NUM_SETS];
  logic [31:0]         data_q [NUM_SETS];

  logic [IDX-1:0]  idx;
  logic [TAGW-1:0] rtag;
  logic            hit;
  logic            miss;
  logic            line_dirty;
  logic            in_idle;
  logic            store_hit;
  logic            fill;
  logic            unused_addr;

  assign idx         = cpu_addr_i[IDX+1:2];
  assign rtag        = cpu_addr_i[31:IDX+2];
  assign unused_addr = ^cpu_addr_i[1:0];

  assign hit = cpu_req_i & valid_q[idx]
             & (tag_q[idx] == rtag);
  assign miss       = cpu_req_i & ~hit;
  assign line_dirty = valid_q[idx] & dirty_q[idx];
  assign in_idle    = (state_q == IDLE);
  assign store_hit  = in_idle & hit & cpu_we_i;
  assign fill       = (state_q == REFILL) & mem_ack_i;

  // Read port is always live; only meaningful on an unstalled load.
  assign cpu_rdata_o = data_q[idx];

  always_comb begin
    state_d     = state_q;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state_q)
      IDLE: begin
        if (miss) begin
          cpu_stall_o = 1'b1;
          state_d = line_dirty ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_q[idx], idx, 2'b00};
        mem_wdata_o = data_q[idx];
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {cpu_addr_i[31:2], 2'b00};
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset abandons any transaction and releases the pipeline at once.
    if (rst_i) begin
      state_d     = IDLE;
      cpu_stall_o = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (fill) begin
        tag_q[idx]  <= rtag;
        data_q[idx] <= mem_rdata_i;
      end else if (store_hit) begin
        data_q[idx] <= cpu_wdata_i;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic        replay_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // The hit that replays a refilled access is not a new hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (fill) begin
        replay_q <= 1'b1;
      end else if (in_idle) begin
        replay_q <= 1'b0;
      end
      if (in_idle & hit & ~replay_q) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (in_idle & miss) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`else
  assign hit_count_o  = '0;
  assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl.
// Reference model is an architectural memory view plus a set/tag map.
module tb_dcache_ctrl;

  localparam int SETS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  dcache_ctrl #(.NUM_SETS(SETS)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .cpu_stall_o (cpu_stall),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .hit_count_o (hit_count),
    .miss_count_o(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] rdata;
    int          stalls;
  } cpu_exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  int checks = 0;
  int failures = 0;

  cpu_exp_t    exp_cpu[$];
  mem_exp_t    exp_mem[$];
  int          lat_q[$];
  logic [31:0] arch[int];
  logic [31:0] mref[int];
  logic [31:0] backing[int];
  bit          mv[SETS];
  bit          md[SETS];
  int          mt[SETS];
  int          exp_hits = 0;
  int          exp_misses = 0;
  bit          auto_mem = 1'b1;
  bit          man_ack = 1'b0;

  function automatic logic [31:0] init_val(int w);
    logic [31:0] x;
    x = 32'(w);
    return (x * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] arch_rd(int w);
    return arch.exists(w) ? arch[w] : init_val(w);
  endfunction

  function automatic logic [31:0] mref_rd(int w);
    return mref.exists(w) ? mref[w] : init_val(w);
  endfunction

  function automatic logic [31:0] back_rd(int w);
    return backing.exists(w) ? backing[w] : init_val(w);
  endfunction

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(string nm);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  task automatic preset(int w, logic [31:0] v);
    arch[w] = v;
    mref[w] = v;
    backing[w] = v;
  endtask

  // Reset loses dirty data that was never written back.
  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      if (mv[s] && md[s]) begin
        arch[mt[s]*SETS+s] = mref_rd(mt[s]*SETS+s);
      end
      mv[s] = 1'b0;
      md[s] = 1'b0;
    end
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic check_stats(string nm);
`ifdef DCACHE_STATS_EN
    check({nm, "_hits"}, hit_count, 32'(exp_hits));
    check({nm, "_misses"}, miss_count, 32'(exp_misses));
`else
    check({nm, "_hits"}, hit_count, 32'd0);
    check({nm, "_misses"}, miss_count, 32'd0);
`endif
  endtask

  task automatic finish_fatal(string nm);
    failures++;
    $display("FAIL %s: got timeout expected progress", nm);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "bench stopped");
  endtask

  // Called at posedge+1; returns at posedge+1 after completion.
  task automatic issue(bit we, int word, logic [31:0] wd,
                       int lwb, int lrf);
    int s;
    int t;
    int ow;
    int n;
    cpu_exp_t ce;
    mem_exp_t me;
    s = word % SETS;
    t = word / SETS;
    ce.stalls = 0;
    if (mv[s] && mt[s] == t) begin
      exp_hits++;
    end else begin
      exp_misses++;
      ce.stalls = 1;
      if (mv[s] && md[s]) begin
        ow = mt[s]*SETS + s;
        me.we = 1'b1;
        me.addr = 32'(ow*4);
        me.wdata = arch_rd(ow);
        mref[ow] = arch_rd(ow);
        exp_mem.push_back(me);
        lat_q.push_back(lwb);
        ce.stalls += lwb;
      end
      me.we = 1'b0;
      me.addr = 32'(word*4);
      me.wdata = '0;
      exp_mem.push_back(me);
      lat_q.push_back(lrf);
      ce.stalls += lrf;
      mv[s] = 1'b1;
      md[s] = 1'b0;
      mt[s] = t;
    end
    if (we) begin
      md[s] = 1'b1;
      arch[word] = wd;
    end
    ce.we = we;
    ce.rdata = arch_rd(word);
    exp_cpu.push_back(ce);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = 32'(word*4) | 32'($urandom_range(0, 3));
    cpu_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cpu_stall && n < 500);
    if (cpu_stall) finish_fatal("access_timeout");
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
  endtask

  // Memory responder: latency N counts request cycles incl. ack.
  initial begin
    int seen;
    int cur;
    seen = 0;
    cur = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!auto_mem) begin
        mem_ack = man_ack;
      end else if (mem_req && !rst) begin
        if (cur == 0) begin
          cur = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
        end
        seen++;
        if (seen >= cur) begin
          mem_ack = 1'b1;
          if (mem_we) backing[int'(mem_addr >> 2)] = mem_wdata;
          else mem_rdata = back_rd(int'(mem_addr >> 2));
          seen = 0;
          cur = 0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents output.
  initial begin
    int stalls;
    bit in_txn;
    logic [31:0] t_addr;
    logic t_we;
    cpu_exp_t ce;
    mem_exp_t me;
    stalls = 0;
    in_txn = 1'b0;
    t_addr = '0;
    t_we = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        stalls = 0;
        in_txn = 1'b0;
      end else begin
        if (cpu_req && cpu_stall) begin
          stalls++;
        end else if (cpu_req) begin
          if (exp_cpu.size() == 0) begin
            unexpected("cpu_completion");
          end else begin
            ce = exp_cpu.pop_front();
            check("stall_cycles", 32'(stalls), 32'(ce.stalls));
            if (!ce.we) check("load_rdata", cpu_rdata, ce.rdata);
          end
          stalls = 0;
        end
        if (!mem_req) begin
          in_txn = 1'b0;
        end else begin
          if (!in_txn) begin
            if (exp_mem.size() == 0) begin
              unexpected("mem_request");
            end else begin
              me = exp_mem.pop_front();
              check("mem_we", {31'b0, mem_we}, {31'b0, me.we});
              check("mem_addr", mem_addr, me.addr);
              if (me.we) check("mem_wdata", mem_wdata, me.wdata);
            end
            in_txn = 1'b1;
            t_addr = mem_addr;
            t_we = mem_we;
          end else begin
            check("mem_addr_hold", mem_addr, t_addr);
            check("mem_we_hold", {31'b0, mem_we}, {31'b0, t_we});
          end
          if (mem_ack) in_txn = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    finish_fatal("watchdog");
  end

  initial begin
    int n;
    mem_exp_t me;
    rst = 1'b1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 32'h40;
    cpu_wdata = '0;
    for (int s = 0; s < SETS; s++) begin
      mv[s] = 1'b0;
      md[s] = 1'b0;
      mt[s] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    check("reset_stall", {31'b0, cpu_stall}, 32'd0);
    check("reset_mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_req = 1'b0;
    check_stats("reset");

    preset(16, 32'hDEAD_BEEF);
    issue(1'b0, 16, '0, 1, 3);
    check_stats("cold_miss");
    issue(1'b0, 16, '0, 1, 1);
    check_stats("load_hit");

    issue(1'b1, 16, 32'h1234_5678, 1, 1);
    issue(1'b0, 32, '0, 2, 2);
    check_stats("dirty_evict");

    issue(1'b1, 65, 32'hA5A5_A5A5, 1, 1);
    issue(1'b0, 65, '0, 1, 1);
    check_stats("store_alloc");

    issue(1'b0, 130, '0, 1, 20);
    check_stats("long_refill");

    for (int i = 0; i < 400; i++) begin
      issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
            $urandom, int'($urandom_range(1, 4)),
            int'($urandom_range(1, 4)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    check_stats("random");

    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    issue(1'b0, 5, '0, 1, 2);

    auto_mem = 1'b0;
    me.we = 1'b0;
    me.addr = 32'(53*4);
    me.wdata = '0;
    exp_mem.push_back(me);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 32'(53*4);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req && !mem_we) && n < 10);
    check("rst_test_refill", {31'b0, mem_req}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("mid_rst_stall", {31'b0, cpu_stall}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_req = 1'b0;
    model_reset();
    man_ack = 1'b1;
    check_stats("after_rst");
    @(negedge clk);
    check("idle_ack_stall", {31'b0, cpu_stall}, 32'd0);
    check("idle_ack_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    @(negedge clk);
    check("post_ack_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    auto_mem = 1'b1;
    issue(1'b0, 5, '0, 1, 2);
    issue(1'b0, 5, '0, 1, 1);
    check_stats("after_rst_reload");

    repeat (3) @(posedge clk);
    check("cpu_queue_empty", 32'(exp_cpu.size()), 32'd0);
    check("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
